// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller: owns the cipher state and round counter,
// drives a shared external round datapath and fetches round keys by handshake.
module aes_round_sequencer #(
    parameter int NR  = 10,
    parameter int BLK = 128
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [BLK-1:0] plaintext,
    input  logic [BLK-1:0] key,
    output logic           key_load,
    output logic [BLK-1:0] key_out,
    output logic           rk_req,
    input  logic           rk_valid,
    input  logic [BLK-1:0] rk_data,
    output logic [BLK-1:0] round_in,
    output logic [BLK-1:0] round_key,
    output logic           last_round,
    input  logic [BLK-1:0] round_out,
    output logic [3:0]     round_num,
    output logic           busy,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [BLK-1:0] ciphertext
);

    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_e;

    state_e         fsm_q, fsm_d;
    logic [BLK-1:0] blk_q, blk_d;
    logic [3:0]     round_q, round_d;

    always_comb begin
        fsm_d   = fsm_q;
        blk_d   = blk_q;
        round_d = round_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    blk_d   = plaintext ^ key;
                    round_d = 4'd1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                if (rk_valid) begin
                    blk_d = round_out;
                    if (round_q == LAST) begin
                        round_d = '0;
                        fsm_d   = DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    blk_d = '0;
                    fsm_d = IDLE;
                end
            end
            default: begin
                blk_d   = '0;
                round_d = '0;
                fsm_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            blk_q   <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            blk_q   <= blk_d;
            round_q <= round_d;
        end
    end

    // Handshake outputs are masked by rst so a block offered during reset is never accepted.
    assign in_ready   = (fsm_q == IDLE) && !rst;
    assign key_load   = (fsm_q == IDLE) && !rst && in_valid;
    assign key_out    = (fsm_q == IDLE) ? key : '0;
    assign rk_req     = (fsm_q == ROUND);
    assign round_in   = blk_q;
    assign round_key  = rk_data;
    assign last_round = (fsm_q == ROUND) && (round_q == LAST);
    assign round_num  = round_q;
    assign busy       = (fsm_q == ROUND) || (fsm_q == DONE);
    assign out_valid  = (fsm_q == DONE);
    assign ciphertext = (fsm_q == DONE) ? blk_q : '0;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer with a behavioural AES round datapath and key schedule.
module tb_aes_round_sequencer;

    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, key_load, rk_req, rk_valid;
    logic         last_round, busy, out_valid, out_ready;
    logic [127:0] plaintext, key, key_out, rk_data, round_in, round_key, round_out, ciphertext;
    logic [3:0]   round_num;

    logic [127:0] rk_tab [0:10];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_round_sequencer #(.NR(10), .BLK(128)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .key(key), .key_load(key_load), .key_out(key_out),
        .rk_req(rk_req), .rk_valid(rk_valid), .rk_data(rk_data),
        .round_in(round_in), .round_key(round_key), .last_round(last_round),
        .round_out(round_out), .round_num(round_num), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .ciphertext(ciphertext)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = '0; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254, then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] s, r;
        s = x; r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   c0, c1, c2, c3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
                b[4*c]   = gmul(8'h02, c0) ^ gmul(8'h03, c1) ^ c2 ^ c3;
                b[4*c+1] = c0 ^ gmul(8'h02, c1) ^ gmul(8'h03, c2) ^ c3;
                b[4*c+2] = c0 ^ c1 ^ gmul(8'h02, c2) ^ gmul(8'h03, c3);
                b[4*c+3] = gmul(8'h03, c0) ^ c1 ^ c2 ^ gmul(8'h02, c3);
            end
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o ^ k;
    endfunction

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]) ^ rc, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    always_comb rk_data = (round_num <= 4'd10) ? rk_tab[round_num] : '0;
    always_comb round_out = aes_rnd(round_in, round_key, last_round);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] ct,
                             input bit stall, input int bp, input bit hold, input int abort_at,
                             input int exp_lat);
        logic [127:0] es;
        int er, stc, t;
        plaintext = pt; key = k; in_valid = 1'b1; out_ready = (bp == 0); rk_valid = 1'b0;
        #1;
        chk("accept_in_ready", 128'(in_ready), 128'd1);
        chk("accept_key_load", 128'(key_load), 128'd1);
        chk("accept_key_out", key_out, k);
        expand(k);
        step;
        if (!hold) in_valid = 1'b0;
        es = pt ^ k; er = 1; stc = 0; t = 1;
        while (out_valid !== 1'b1 && t < 100) begin
            if (er == abort_at) begin
                rst = 1'b1;
                step;
                rst = 1'b0;
                #1;
                chk("rst_in_ready", 128'(in_ready), 128'd1);
                chk("rst_out_valid", 128'(out_valid), 128'd0);
                chk("rst_round_num", 128'(round_num), 128'd0);
                chk("rst_busy", 128'(busy), 128'd0);
                chk("rst_rk_req", 128'(rk_req), 128'd0);
                chk("rst_state", round_in, 128'd0);
                chk("rst_ciphertext", ciphertext, 128'd0);
                return;
            end
            chk("round_num", 128'(round_num), 128'(er));
            chk("last_round", 128'(last_round), 128'(er == 10));
            chk("round_rk_req", 128'(rk_req), 128'd1);
            chk("round_busy", 128'(busy), 128'd1);
            chk("round_in_ready", 128'(in_ready), 128'd0);
            chk("round_key_load", 128'(key_load), 128'd0);
            chk("round_state", round_in, es);
            chk("round_ciphertext", ciphertext, 128'd0);
            rk_valid = !stall || (stc == 3);
            if (rk_valid) begin
                es = aes_rnd(es, rk_tab[er], er == 10);
                er++; stc = 0;
            end else begin
                stc++;
            end
            step;
            t++;
        end
        rk_valid = 1'b0;
        chk("latency", 128'(t), 128'(exp_lat));
        chk("done_ciphertext", ciphertext, ct);
        chk("done_out_valid", 128'(out_valid), 128'd1);
        chk("done_busy", 128'(busy), 128'd1);
        chk("done_in_ready", 128'(in_ready), 128'd0);
        chk("done_key_load", 128'(key_load), 128'd0);
        chk("done_round_num", 128'(round_num), 128'd0);
        chk("done_rk_req", 128'(rk_req), 128'd0);
        for (int i = 1; i < bp; i++) begin
            step;
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_ciphertext", ciphertext, ct);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        step;
        chk("idle_in_ready", 128'(in_ready), 128'd1);
        chk("idle_out_valid", 128'(out_valid), 128'd0);
        chk("idle_busy", 128'(busy), 128'd0);
        chk("idle_ciphertext", ciphertext, 128'd0);
        chk("idle_state", round_in, 128'd0);
        chk("idle_key_load", 128'(key_load), 128'(hold));
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; rk_valid = 1'b0; out_ready = 1'b0;
        plaintext = '0; key = '0;
        for (int r = 0; r < 11; r++) rk_tab[r] = '0;
        step; step;
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_rk_req", 128'(rk_req), 128'd0);
        chk("reset_round_num", 128'(round_num), 128'd0);
        chk("reset_state", round_in, 128'd0);
        chk("reset_ciphertext", ciphertext, 128'd0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 128'(in_ready), 128'd1);

        rk_valid = 1'b1; out_ready = 1'b1;
        step; step;
        chk("ign_busy", 128'(busy), 128'd0);
        chk("ign_round_num", 128'(round_num), 128'd0);
        chk("ign_state", round_in, 128'd0);
        chk("ign_in_ready", 128'(in_ready), 128'd1);
        rk_valid = 1'b0; out_ready = 1'b0;

        run_block(PT1, K1, CT1, 1'b0, 0, 1'b0, 0, 11);
        run_block(PT1, K1, CT1, 1'b1, 0, 1'b0, 0, 41);
        run_block(PT1, K1, CT1, 1'b0, 5, 1'b0, 0, 11);
        run_block(PT1, K1, CT1, 1'b0, 0, 1'b1, 0, 11);
        run_block('0, '0, CT0, 1'b0, 0, 1'b0, 0, 11);
        run_block(PT1, K1, CT1, 1'b0, 0, 1'b0, 5, 11);

        rst = 1'b1; in_valid = 1'b1; plaintext = PT1; key = K1;
        #1;
        chk("rstwin_key_load", 128'(key_load), 128'd0);
        chk("rstwin_in_ready", 128'(in_ready), 128'd0);
        step;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rstwin_busy", 128'(busy), 128'd0);
        chk("rstwin_in_ready", 128'(in_ready), 128'd1);

        run_block(PT1, K1, CT1, 1'b0, 0, 1'b0, 0, 11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Iterative AES-128 encryption controller.
- Owns the 128-bit cipher state register and the round counter.
- Sequences one shared combinational round datapath (SubBytes -> ShiftRows -> MixColumns -> AddRoundKey) over rounds 1..10, with MixColumns bypassed in round 10.
- Fetches round keys from an external key scheduler through a valid handshake, and presents ciphertext on a valid/ready output handshake.

Parameters:
- NR, 10, number of cipher rounds (AES-128); round counter is 4 bits wide.
- BLK, 128, block and key width in bits.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  plaintext/key offered
- in_ready  output  1  sequencer can accept a block
- plaintext  input  128  block to encrypt, byte order {MSB..LSB} column-major
- key  input  128  cipher key, same byte order
- key_load  output  1  one-cycle pulse: key scheduler must latch key_out
- key_out  output  128  key forwarded to scheduler, valid with key_load
- rk_req  output  1  round key for round_num requested
- rk_valid  input  1  rk_data valid for requested round_num
- rk_data  input  128  round key for round_num
- round_in  output  128  current state to datapath (equals state register)
- round_key  output  128  key to datapath AddRoundKey (equals rk_data)
- last_round  output  1  datapath must bypass MixColumns
- round_out  input  128  combinational datapath result
- round_num  output  4  current round, 1..NR; 0 when not in ROUND
- busy  output  1  high in ROUND or DONE
- out_valid  output  1  ciphertext valid
- out_ready  input  1  consumer accepts ciphertext
- ciphertext  output  128  result (equals state register in DONE, else 0)

Behaviour:
- Reset values: all outputs 0 except in_ready = 1 once out of reset; state register 0, round 0, FSM = IDLE.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: state <= plaintext ^ key (round-0 AddRoundKey); round <= 1; key_load = 1 for this cycle with key_out = key; next state ROUND.
  - key_out = key combinationally in IDLE, else 0.
- ROUND:
  - rk_req = 1; round_num = round; last_round = (round == NR).
  - rk_valid = 0: stall, no state change, outputs held.
  - rk_valid = 1: state <= round_out.
    - If round == NR: next state DONE, round <= 0.
    - Else: round <= round + 1.
- DONE:
  - out_valid = 1; ciphertext = state.
  - Outputs held stable while out_ready = 0.
  - On out_ready: next state IDLE, state cleared to 0.
  - No new block is accepted in the same cycle (in_ready is low in DONE).
- Latency: with rk_valid tied high, out_valid rises exactly NR+1 = 11 cycles after the accept edge. Throughput is 1 block per 12 cycles minimum.
- rk_valid outside ROUND is ignored. out_ready outside DONE is ignored. in_valid outside IDLE is ignored (in_ready = 0).
- round never exceeds NR and never wraps.
- rst asserted in any state, including mid-round or mid-stall: next edge returns IDLE, clears state and round, drops out_valid, rk_req, busy and key_load. No partial result is emitted.
- Simultaneous rst and in_valid: rst wins, block not accepted.

Test Plan:
- FIPS-197 vector: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, rk_valid tied high, out_ready high -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 11 cycles after accept; key_load one pulse; round_num sequence 1..10 with last_round only at 10.
- Same vector with rk_valid low 3 cycles before every round -> identical ciphertext; latency 11 + 30 = 41 cycles; state and round_num held during stalls.
- Output backpressure: out_ready held low 5 cycles in DONE -> out_valid and ciphertext stable; in_ready stays 0; IDLE entered on the cycle after out_ready rises.
- Back-to-back: two blocks (FIPS vector, then all-zero plaintext with all-zero key) with in_valid held high -> second accepted only after return to IDLE; second ciphertext 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Reset mid-operation: assert rst during round 5 -> next cycle IDLE, in_ready = 1, out_valid = 0, round_num = 0; a new FIPS vector then produces the correct ciphertext.
- Ignored inputs: rk_valid pulses in IDLE and out_ready pulses in ROUND -> no state or round change.
